ppl_ctrl: RTL and testbench
===========================

PPL_CTRL -- requirements
Module: ppl_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: ID_rs1, ID_rs2  in  3 each  source register indices of the instruction in ID.
REQ-004 SHALL have ports: ID_rs1_use, ID_rs2_use  in  1 each  source actually read.
REQ-005 SHALL have ports: EX_rd  in  3  destination index in EX; EX_load  in  1  EX holds a load (mem read with RegWe).
REQ-006 SHALL have ports: EX_jump  in  1  branch/jump taken, resolved in EX.
REQ-007 SHALL have ports: mem_req  in  1  MEM-stage access request; mem_ack  in  1  access complete.
REQ-008 SHALL have ports: dbg_halt  in  1  debug halt request, level.
REQ-009 SHALL have ports: hold_flag  out  `HOLDBUS  pipeline hold code; clear_flag  out  `CLEARBUS  pipeline clear code.
REQ-010 SHALL have ports: bus_err  out  1  one-cycle memory timeout pulse; halted  out  1  in HALT; stall_cnt  out  16  stall-cycle counter.
REQ-011 SHALL have parameter TIMEOUT, default 255, max MEM_WAIT cycles before bus_err (1..255).

Function
REQ-012 SHALL encode holds: Hold_None=0, Hold_PC=1, Hold_ID=2 (PC+IF/ID), Hold_EX=3 (PC..ID/EX), Hold_PPL=4 (all stages).
REQ-013 SHALL encode clears: Clear_None=0, Clear_ID=1 (IF/ID), Clear_EX=2 (ID/EX), Clear_IDEX=3 (both), Clear_PPL=4 (all).
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, HALT; hold/clear outputs are combinational from state and current inputs (same-cycle).
REQ-015 RUN, priority high to low: mem_req&~mem_ack -> Hold_PPL, Clear_None, next MEM_WAIT; dbg_halt -> Hold_PPL, next HALT; EX_jump -> Hold_None, Clear_IDEX; load-use -> Hold_ID, Clear_EX; else None/None.
REQ-016 Load-use SHALL be EX_load & EX_rd!=0 & ((ID_rs1_use & ID_rs1==EX_rd) | (ID_rs2_use & ID_rs2==EX_rd)); register 0 never stalls.
REQ-017 mem_req&mem_ack in same RUN cycle SHALL not stall; lower-priority rules then apply.
REQ-018 MEM_WAIT: Hold_PPL while ~mem_ack; on mem_ack output Hold_None/Clear_None, next RUN; EX_jump and load-use ignored (re-evaluated after release, since EX is held).
REQ-019 MEM_WAIT SHALL count wait cycles in an 8-bit counter cleared on entry; on count==TIMEOUT without ack: bus_err=1, Clear_PPL, Hold_None, next RUN.
REQ-020 mem_ack on the same cycle as timeout SHALL win: no bus_err, normal release.
REQ-021 HALT: Hold_PPL while dbg_halt; on deassert Hold_None, next RUN; halted=1 exactly while state==HALT; a mem_req arriving in HALT is held, serviced via RUN next cycle.
REQ-022 stall_cnt SHALL increment every cycle hold_flag!=Hold_None, saturate at 16'hFFFF, never wrap.
REQ-023 bus_err SHALL be a single-cycle pulse per timeout.

Reset
REQ-024 While rst=1: state RUN, wait counter 0, stall_cnt 0, bus_err 0, halted 0, hold_flag Hold_None, clear_flag Clear_PPL.
REQ-025 rst mid-MEM_WAIT or mid-HALT SHALL abandon state without bus_err; first post-reset cycle evaluates RUN rules.

Structure
REQ-026 Hold_*/Clear_* codes, `HOLDBUS/`CLEARBUS (3 bits each) SHALL live in shared para.v, consumed by all pipeline registers.
REQ-027 SHALL be flat single module; no sub-modules.

Verification
REQ-028 EX_load=1, EX_rd=3, ID_rs2=3, rs2_use=1 -> same cycle Hold_ID/Clear_EX, next cycle (load gone) None/None, stall_cnt=1.
REQ-029 EX_load=1, EX_rd=0, ID_rs1=0 -> no stall; EX_jump=1 with load-use -> Clear_IDEX, Hold_None.
REQ-030 mem_req, ack after 4 cycles -> Hold_PPL 4 cycles, release on ack cycle, stall_cnt=4, EX_jump held throughout then Clear_IDEX next cycle.
REQ-031 TIMEOUT=5, mem_req, no ack -> Hold_PPL 5 cycles, then bus_err 1 cycle with Clear_PPL, state RUN; repeat with ack on timeout cycle -> no bus_err.
REQ-032 dbg_halt 3 cycles, rst pulsed in 2nd -> halted drops, Clear_PPL during rst, stall_cnt=0; re-enters HALT after reset if dbg_halt still high.

Source files
------------

// File: rtl/ppl_ctrl_pkg.sv
// ppl_ctrl_pkg: shared hold/clear codes and controller state encoding
package ppl_ctrl_pkg;
  localparam int HOLD_W = 3;
  localparam int CLEAR_W = 3;
  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_ID   = 3'd2,
    HOLD_EX   = 3'd3,
    HOLD_PPL  = 3'd4
  } hold_e;
  typedef enum logic [CLEAR_W-1:0] {
    CLEAR_NONE = 3'd0,
    CLEAR_ID   = 3'd1,
    CLEAR_EX   = 3'd2,
    CLEAR_IDEX = 3'd3,
    CLEAR_PPL  = 3'd4
  } clear_e;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;
  function automatic logic load_use(
    input logic [2:0] rs1, input logic [2:0] rs2,
    input logic       rs1_use, input logic rs2_use,
    input logic [2:0] rd, input logic ld
  );
    return ld && rd != 3'd0 && ((rs1_use && rs1 == rd) || (rs2_use && rs2 == rd));
  endfunction
endpackage

// File: rtl/ppl_ctrl_if.sv
// ppl_ctrl_if: pipeline hazard/stall controller signal bundle
interface ppl_ctrl_if;
  import ppl_ctrl_pkg::*;
  logic [2:0] ID_rs1;
  logic [2:0] ID_rs2;
  logic       ID_rs1_use;
  logic       ID_rs2_use;
  logic [2:0] EX_rd;
  logic       EX_load;
  logic       EX_jump;
  logic       mem_req;
  logic       mem_ack;
  logic       dbg_halt;
  hold_e      hold_flag;
  clear_e     clear_flag;
  logic       bus_err;
  logic       halted;
  logic [15:0] stall_cnt;
  modport master (
    output ID_rs1, ID_rs2, ID_rs1_use, ID_rs2_use, EX_rd, EX_load, EX_jump,
           mem_req, mem_ack, dbg_halt,
    input  hold_flag, clear_flag, bus_err, halted, stall_cnt
  );
  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_use, ID_rs2_use, EX_rd, EX_load, EX_jump,
           mem_req, mem_ack, dbg_halt,
    output hold_flag, clear_flag, bus_err, halted, stall_cnt
  );
endinterface

// File: rtl/ppl_ctrl.sv
// ppl_ctrl: pipeline hold/clear controller with load-use, memory-wait timeout and debug halt
module ppl_ctrl
  import ppl_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ppl_ctrl_if.slave p
);
  state_e st, nxt;
  hold_e hold;
  clear_e clr;
  logic err;
  logic lu;
  logic [7:0] cnt;
  logic [15:0] stall;
  assign lu = load_use(p.ID_rs1, p.ID_rs2, p.ID_rs1_use, p.ID_rs2_use, p.EX_rd, p.EX_load);
  always_comb begin
    nxt = st;
    hold = HOLD_NONE;
    clr = CLEAR_NONE;
    err = 1'b0;
    if (rst) begin
      nxt = RUN;
      clr = CLEAR_PPL;
    end else begin
      case (st)
        RUN: begin
          if (p.mem_req && !p.mem_ack) begin
            hold = HOLD_PPL;
            nxt = MEM_WAIT;
          end else if (p.dbg_halt) begin
            hold = HOLD_PPL;
            nxt = HALT;
          end else if (p.EX_jump) begin
            clr = CLEAR_IDEX;
          end else if (lu) begin
            hold = HOLD_ID;
            clr = CLEAR_EX;
          end
        end
        MEM_WAIT: begin
          if (p.mem_ack) begin
            nxt = RUN;
          end else if (cnt == 8'(TIMEOUT)) begin
            err = 1'b1;
            clr = CLEAR_PPL;
            nxt = RUN;
          end else begin
            hold = HOLD_PPL;
          end
        end
        HALT: begin
          if (p.dbg_halt) hold = HOLD_PPL;
          else nxt = RUN;
        end
        default: nxt = RUN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      cnt <= 8'd0;
      stall <= 16'd0;
    end else begin
      st <= nxt;
      cnt <= (nxt == MEM_WAIT) ? cnt + 8'd1 : 8'd0;
      stall <= (hold != HOLD_NONE && stall != 16'hFFFF) ? stall + 16'd1 : stall;
    end
  end
  assign p.hold_flag = hold;
  assign p.clear_flag = clr;
  assign p.bus_err = err;
  assign p.halted = (st == HALT) && !rst;
  assign p.stall_cnt = stall;
endmodule

// File: tb/tb_ppl_ctrl.sv
// tb_ppl_ctrl: scoreboard bench for ppl_ctrl against a cycle-level reference model
module tb_ppl_ctrl;
  import ppl_ctrl_pkg::*;
  localparam int TO = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ppl_ctrl_if ifc ();
  ppl_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .p(ifc.slave));
  always #5 clk = ~clk;
  typedef struct {
    int hold;
    int clr;
    int err;
    int hlt;
    int stall;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit m_wait = 0;
  int m_waited = 0;
  bit m_halt = 0;
  int m_stalls = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(
    input logic r, input logic [2:0] rs1, input logic [2:0] rs2,
    input logic u1, input logic u2, input logic [2:0] rd, input logic ld,
    input logic jmp, input logic req, input logic ack, input logic hlt
  );
    exp_t e;
    bit lu;
    @(posedge clk);
    #1;
    rst = r;
    ifc.ID_rs1 = rs1;
    ifc.ID_rs2 = rs2;
    ifc.ID_rs1_use = u1;
    ifc.ID_rs2_use = u2;
    ifc.EX_rd = rd;
    ifc.EX_load = ld;
    ifc.EX_jump = jmp;
    ifc.mem_req = req;
    ifc.mem_ack = ack;
    ifc.dbg_halt = hlt;
    e = '{hold: 0, clr: 0, err: 0, hlt: 0, stall: m_stalls};
    lu = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (r) begin
      e.clr = 4;
      m_wait = 0;
      m_halt = 0;
      m_waited = 0;
      m_stalls = 0;
    end else begin
      if (m_wait) begin
        if (ack) m_wait = 0;
        else if (m_waited == TO) begin
          e.err = 1;
          e.clr = 4;
          m_wait = 0;
        end else begin
          e.hold = 4;
          m_waited++;
        end
      end else if (m_halt) begin
        e.hlt = 1;
        if (hlt) e.hold = 4;
        else m_halt = 0;
      end else if (req && !ack) begin
        e.hold = 4;
        m_wait = 1;
        m_waited = 1;
      end else if (hlt) begin
        e.hold = 4;
        m_halt = 1;
      end else if (jmp) e.clr = 3;
      else if (lu) begin
        e.hold = 2;
        e.clr = 2;
      end
      if (e.hold != 0 && m_stalls < 65535) m_stalls++;
    end
    q.push_back(e);
  endtask
  task automatic idle(input logic r);
    step(r, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hold_flag", int'(ifc.hold_flag), e.hold);
        chk("clear_flag", int'(ifc.clear_flag), e.clr);
        chk("bus_err", int'(ifc.bus_err), e.err);
        chk("halted", int'(ifc.halted), e.hlt);
        chk("stall_cnt", int'(ifc.stall_cnt), e.stall);
      end
    end
  end
  initial begin : stim
    bit pend_req;
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    step(0, 3'd5, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 3'd4, 3'd1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 4; i++)
      step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 6; i++)
      step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++)
      step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    pend_req = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend_req) pend_req = ($urandom % 5) == 0;
      step(($urandom % 200) == 0, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom % 4), ($urandom % 3) == 0, ($urandom % 6) == 0,
           pend_req, ($urandom % 3) == 0, ($urandom % 8) == 0);
      if (ifc.mem_ack || ifc.bus_err) pend_req = 0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
